hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It generates the write-enable, flush and bubble controls for the PC, IF/ID and ID/EX pipeline registers. It handles load-use hazards, taken-branch/jump flushes and multi-cycle multiply/divide occupancy of EX. It also keeps a saturating count of stall cycles for performance monitoring. It sits beside the ID stage and drives the enable/flush inputs of the pipeline registers and the control-zeroing mux in front of ID/EX (WB, M and EX control groups).

---
 rtl/hazard_stall_ctrl_if.sv | 29 ++
 rtl/hazard_stall_ctrl.sv | 85 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle between the ID-stage decode and the pipeline register controls.
// slave = the stall controller, master = the pipeline side that feeds it and obeys it.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             id_branch_taken;
  logic             id_md_start;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, id_branch_taken, id_md_start,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, id_branch_taken, id_md_start,
    output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes, mult/div EX occupancy
// and a saturating stall-cycle counter. Outputs are combinational from state and inputs.
module hazard_stall_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave hz
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;

  assign load_use = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                    ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_busy     = 1'b0;
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      md_cnt_d    = '0;
    end else if (state_q == MD_WAIT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      md_busy     = 1'b1;
      if (md_cnt_q == 4'd0) state_d = RUN;
      else                  md_cnt_d = md_cnt_q - 4'd1;
    end else if (load_use) begin
      // Branch and mult/div in ID are held and re-evaluated once the load leaves EX.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (hz.id_branch_taken) begin
      ifid_flush = 1'b1;
    end else if (hz.id_md_start) begin
      state_d  = MD_WAIT;
      md_cnt_d = 4'(MD_CYCLES - 1);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (rst)                            stall_d = '0;
    else if (!pc_write && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.md_busy     = md_busy;
  assign hz.stall_count = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a table of per-cycle vectors with hand-derived expectations,
// queued at drive time and compared at sample time, plus a bounded mult/div wait sequence.
module tb_hazard_stall_ctrl;

  logic clk;
  logic rst;

  hazard_stall_ctrl_if #(.CNT_W(16)) if_m ();
  hazard_stall_ctrl_if #(.CNT_W(4))  if_s ();

  hazard_stall_ctrl #(.MD_CYCLES(4), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .hz(if_m.slave));
  hazard_stall_ctrl #(.MD_CYCLES(4), .CNT_W(4))  u_sat (.clk(clk), .rst(rst), .hz(if_s.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs, rt;
    logic       uses_rt, memread;
    logic [4:0] ex_rt;
    logic       br, md;
    logic       pcw, ifw, flush, bub, busy;
    int         cnt;   // -1: counter not yet defined
    int         cnt4;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(string name, logic r, logic [4:0] rs, logic [4:0] rt, logic ur,
                              logic mr, logic [4:0] ert, logic br, logic md,
                              logic [4:0] outs, int cnt);
    vec_t v;
    v.name = name; v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.memread = mr;
    v.ex_rt = ert; v.br = br; v.md = md;
    {v.pcw, v.ifw, v.flush, v.bub, v.busy} = outs;
    v.cnt  = cnt;
    v.cnt4 = (cnt > 15) ? 15 : cnt;
    return v;
  endfunction

  // Output patterns {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy}
  localparam logic [4:0] O_N = 5'b11000;
  localparam logic [4:0] O_S = 5'b00010;
  localparam logic [4:0] O_R = 5'b00110;
  localparam logic [4:0] O_B = 5'b11100;
  localparam logic [4:0] O_W = 5'b00011;

  task automatic drive(input vec_t v);
    rst = v.rst;
    if_m.id_rs = v.rs; if_m.id_rt = v.rt; if_m.id_uses_rt = v.uses_rt;
    if_m.ex_memread = v.memread; if_m.ex_rt = v.ex_rt;
    if_m.id_branch_taken = v.br; if_m.id_md_start = v.md;
    if_s.id_rs = v.rs; if_s.id_rt = v.rt; if_s.id_uses_rt = v.uses_rt;
    if_s.ex_memread = v.memread; if_s.ex_rt = v.ex_rt;
    if_s.id_branch_taken = v.br; if_s.id_md_start = v.md;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    int nb;
    rst = 1'b1;
    // name, rst, rs, rt, uses_rt, memread, ex_rt, br, md, outputs, stall_count
    vecs.push_back(mk("rst0",      1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, O_R, -1));
    vecs.push_back(mk("rst1",      1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_R, 0));
    vecs.push_back(mk("idle",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_N, 0));
    vecs.push_back(mk("lu_rs",     0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, O_S, 0));
    vecs.push_back(mk("lu_done",   0, 5'd5, 5'd0, 0, 0, 5'd5, 0, 0, O_N, 1));
    vecs.push_back(mk("lu_r0",     0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, O_N, 1));
    vecs.push_back(mk("lu_rt",     0, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, O_S, 1));
    vecs.push_back(mk("rt_unused", 0, 5'd3, 5'd7, 0, 1, 5'd7, 0, 0, O_N, 2));
    vecs.push_back(mk("br_vs_lu",  0, 5'd9, 5'd0, 0, 1, 5'd9, 1, 0, O_S, 2));
    vecs.push_back(mk("br_go",     0, 5'd9, 5'd0, 0, 0, 5'd9, 1, 0, O_B, 3));
    vecs.push_back(mk("br_vs_md",  0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, O_B, 3));
    vecs.push_back(mk("after_br",  0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_N, 3));
    vecs.push_back(mk("lu_vs_md",  0, 5'd2, 5'd0, 0, 1, 5'd2, 0, 1, O_S, 3));
    vecs.push_back(mk("md_T",      0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_N, 4));
    vecs.push_back(mk("md_T1",     0, 5'd6, 5'd0, 0, 1, 5'd6, 1, 1, O_W, 4));
    vecs.push_back(mk("md_T2",     0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, O_W, 5));
    vecs.push_back(mk("md_T3",     0, 5'd6, 5'd0, 0, 1, 5'd6, 0, 1, O_W, 6));
    vecs.push_back(mk("md_T4",     0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_W, 7));
    vecs.push_back(mk("md_T5",     0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_N, 8));
    vecs.push_back(mk("b2b_1st",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_N, 8));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("b2b_wait", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_W, 8 + i));
    vecs.push_back(mk("b2b_2nd",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_N, 12));
    vecs.push_back(mk("b2b_T1",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_W, 12));
    vecs.push_back(mk("rst_wait",  1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_R, 13));
    vecs.push_back(mk("after_rst", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_N, 0));
    for (int k = 0; k < 20; k++)
      vecs.push_back(mk("sat_lu",  0, 5'd4, 5'd0, 0, 1, 5'd4, 0, 0, O_S, k));
    vecs.push_back(mk("sat_end",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_N, 20));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      chk({e.name, ".pc_write"},    int'(if_m.pc_write),    int'(e.pcw));
      chk({e.name, ".ifid_write"},  int'(if_m.ifid_write),  int'(e.ifw));
      chk({e.name, ".ifid_flush"},  int'(if_m.ifid_flush),  int'(e.flush));
      chk({e.name, ".idex_bubble"}, int'(if_m.idex_bubble), int'(e.bub));
      chk({e.name, ".md_busy"},     int'(if_m.md_busy),     int'(e.busy));
      if (e.cnt >= 0) begin
        chk({e.name, ".stall_count"},   int'(if_m.stall_count), e.cnt);
        chk({e.name, ".stall_count_4"}, int'(if_s.stall_count), e.cnt4);
      end
    end

    // Mult/div from a fresh reset: count busy cycles with a bounded wait.
    @(negedge clk);
    drive(mk("seq_rst", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_R, 0));
    @(negedge clk);
    drive(mk("seq_md", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, O_N, 0));
    #1;
    chk("seq_md.pc_write", int'(if_m.pc_write), 1);
    @(negedge clk);
    drive(mk("seq_idle", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, O_N, 0));
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!if_m.md_busy) break;
      nb++;
      @(negedge clk);
    end
    chk("seq.busy_cycles",    nb, 4);
    chk("seq.resume_pcw",     int'(if_m.pc_write), 1);
    chk("seq.stall_count",    int'(if_m.stall_count), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
